// File: rtl/adder_tree_pkg.sv
// Shared helpers for the adder-tree accumulator: width math, per-level node counts, saturation bounds.
// Latency: none (compile-time functions and types only).
// Backpressure: not applicable.
package adder_tree_pkg;

    // Upper and lower clamp limits, wide enough for any practical OUT_W.
    typedef struct packed {
        logic signed [127:0] hi;
        logic signed [127:0] lo;
    } sat_bounds_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width carried through every tree level: enough headroom for the full sum.
    function automatic int tree_w(input int in_w, input int num_in);
        return in_w + clog2(num_in);
    endfunction

    // Number of nodes present at level lvl: ceil(num_in / 2^lvl).
    function automatic int level_nodes(input int num_in, input int lvl);
        return (num_in + (1 << lvl) - 1) >> lvl;
    endfunction

    // Index of the first node of level lvl when all levels are packed end to end.
    function automatic int node_offset(input int num_in, input int lvl);
        int o;
        o = 0;
        for (int j = 0; j < lvl; j++) o += level_nodes(num_in, j);
        return o;
    endfunction

    // Representable range of an out_w-bit accumulator.
    function automatic sat_bounds_t sat_bounds(input int out_w, input bit sgn);
        sat_bounds_t b;
        logic signed [127:0] one;
        one = 128'sd1;
        if (sgn) begin
            b.hi = (one <<< (out_w - 1)) - one;
            b.lo = -(one <<< (out_w - 1));
        end else begin
            b.hi = (one <<< out_w) - one;
            b.lo = '0;
        end
        return b;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder-tree level: adds node pairs (2k, 2k+1), passes an odd trailing node through.
// Latency: 1 cycle.
// Backpressure: holds all state while en is low; no internal buffering.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int N_DST = level_nodes(N_SRC, 1),
    parameter int W     = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               src_valid,
    input  logic               src_last,
    input  logic [N_SRC*W-1:0] src_data,
    output logic               sum_valid,
    output logic               sum_last,
    output logic [N_DST*W-1:0] sum_data
);

    logic [N_DST*W-1:0] pair_sum;

    // Node width already includes the headroom for the whole tree, so pair sums never overflow.
    genvar k;
    generate
        for (k = 0; k < N_DST; k++) begin : g_node
            if (2 * k + 1 < N_SRC) begin : g_pair
                assign pair_sum[k*W +: W] = src_data[(2*k)*W +: W] + src_data[(2*k+1)*W +: W];
            end else begin : g_pass
                assign pair_sum[k*W +: W] = src_data[(2*k)*W +: W];
            end
        end
    endgenerate

    // Register the level together with its valid/last tags; freeze when the pipeline stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
            sum_data  <= '0;
        end else if (en) begin
            sum_valid <= src_valid;
            sum_last  <= src_last;
            sum_data  <= pair_sum;
        end
    end

endmodule

// File: rtl/adder_tree_accum.sv
// Sums NUM_IN channels per beat in a registered tree, then accumulates beats into per-group results.
// Latency: D+1 cycles (D = clog2(NUM_IN)) from the accepting edge of a last beat to m_valid.
// Backpressure: whole pipeline freezes while a result waits on m_ready; s_ready mirrors that.
module adder_tree_accum
    import adder_tree_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 24,
    parameter int SIGNED = 1,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NUM_IN*IN_W-1:0] s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OUT_W-1:0]       m_data,
    output logic                   m_sat,
    output logic [CNT_W-1:0]       m_count
);

    localparam int  D         = clog2(NUM_IN);
    localparam int  TW        = tree_w(IN_W, NUM_IN);
    localparam int  TOTAL     = node_offset(NUM_IN, D + 1);
    localparam int  SW        = OUT_W + 2;
    localparam bit  IS_SIGNED = (SIGNED != 0);
    localparam bit  SAT_ON    = (SAT_EN != 0);

    localparam sat_bounds_t           SAT_B  = sat_bounds(OUT_W, IS_SIGNED);
    localparam logic signed [SW-1:0]  SAT_HI = SAT_B.hi[SW-1:0];
    localparam logic signed [SW-1:0]  SAT_LO = SAT_B.lo[SW-1:0];

    // All tree levels packed end to end; level 0 is the extended input, the last node is the tree sum.
    logic [TOTAL*TW-1:0] node_bus;
    logic [D:0]          lvl_valid;
    logic [D:0]          lvl_last;
    logic                adv;
    logic [TW-1:0]       tree_sum;

    logic [OUT_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic                sticky;

    logic [SW-1:0]        acc_x;
    logic [SW-1:0]        sum_x;
    logic signed [SW-1:0] raw;
    logic [OUT_W-1:0]     nxt;
    logic                 clamp;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 sticky_nxt;

    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    assign lvl_valid[0] = s_valid;
    assign lvl_last[0]  = s_last;

    // Extend every channel to tree width so later levels add at full precision.
    genvar k;
    generate
        for (k = 0; k < NUM_IN; k++) begin : g_ext
            assign node_bus[k*TW +: TW] = IS_SIGNED
                ? {{D{s_data[k*IN_W + IN_W - 1]}}, s_data[k*IN_W +: IN_W]}
                : {{D{1'b0}}, s_data[k*IN_W +: IN_W]};
        end
    endgenerate

    genvar l;
    generate
        for (l = 0; l < D; l++) begin : g_lvl
            localparam int NS = level_nodes(NUM_IN, l);
            localparam int ND = level_nodes(NUM_IN, l + 1);
            localparam int OS = node_offset(NUM_IN, l);
            localparam int OD = node_offset(NUM_IN, l + 1);

            adder_tree_level #(
                .N_SRC (NS),
                .N_DST (ND),
                .W     (TW)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (adv),
                .src_valid (lvl_valid[l]),
                .src_last  (lvl_last[l]),
                .src_data  (node_bus[OS*TW +: NS*TW]),
                .sum_valid (lvl_valid[l+1]),
                .sum_last  (lvl_last[l+1]),
                .sum_data  (node_bus[OD*TW +: ND*TW])
            );
        end
    endgenerate

    assign tree_sum = node_bus[TOTAL*TW-1 -: TW];

    // Next accumulator value: exact sum with two guard bits, then clamp or wrap to OUT_W.
    always_comb begin
        acc_x      = IS_SIGNED ? {{2{acc[OUT_W-1]}}, acc} : {2'b00, acc};
        sum_x      = {{(SW-TW){IS_SIGNED && tree_sum[TW-1]}}, tree_sum};
        raw        = acc_x + sum_x;
        nxt        = raw[OUT_W-1:0];
        clamp      = 1'b0;
        if (SAT_ON && (raw > SAT_HI)) begin
            nxt   = SAT_HI[OUT_W-1:0];
            clamp = 1'b1;
        end else if (SAT_ON && (raw < SAT_LO)) begin
            nxt   = SAT_LO[OUT_W-1:0];
            clamp = 1'b1;
        end
        cnt_nxt    = (&cnt) ? cnt : cnt + CNT_W'(1);
        sticky_nxt = sticky || clamp;
    end

    // Accumulate beats leaving the tree; a last beat publishes the group and restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
            m_count <= '0;
        end else if (adv) begin
            m_valid <= lvl_valid[D] && lvl_last[D];
            if (lvl_valid[D]) begin
                if (lvl_last[D]) begin
                    m_data  <= nxt;
                    m_sat   <= SAT_ON && sticky_nxt;
                    m_count <= cnt_nxt;
                    acc     <= '0;
                    cnt     <= '0;
                    sticky  <= 1'b0;
                end else begin
                    acc     <= nxt;
                    cnt     <= cnt_nxt;
                    sticky  <= sticky_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_accum.sv
module tb_adder_tree_accum;

    localparam int NI  = 8;
    localparam int IW  = 16;
    localparam int OWA = 24;
    localparam int OWB = 20;
    localparam int CW  = 16;
    localparam int NIC = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              ab_s_valid;
    logic              ab_s_last;
    logic [NI*IW-1:0]  ab_s_data;
    logic              ab_m_ready;
    logic              rdy_fix;
    logic              rr_en;
    logic              rr_bit;

    logic              a_s_ready, a_m_valid, a_m_sat;
    logic [OWA-1:0]    a_m_data;
    logic [CW-1:0]     a_m_count;
    logic              b_s_ready, b_m_valid, b_m_sat;
    logic [OWB-1:0]    b_m_data;
    logic [CW-1:0]     b_m_count;

    logic              c_s_valid, c_s_last, c_m_ready;
    logic [NIC*IW-1:0] c_s_data;
    logic              c_s_ready, c_m_valid, c_m_sat;
    logic [OWA-1:0]    c_m_data;
    logic [CW-1:0]     c_m_count;

    assign ab_m_ready = rr_en ? rr_bit : rdy_fix;

    adder_tree_accum #(.NUM_IN(NI), .IN_W(IW), .OUT_W(OWA), .SIGNED(1), .SAT_EN(0), .CNT_W(CW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(ab_s_valid), .s_ready(a_s_ready), .s_data(ab_s_data),
        .s_last(ab_s_last), .m_valid(a_m_valid), .m_ready(ab_m_ready), .m_data(a_m_data),
        .m_sat(a_m_sat), .m_count(a_m_count));

    adder_tree_accum #(.NUM_IN(NI), .IN_W(IW), .OUT_W(OWB), .SIGNED(1), .SAT_EN(1), .CNT_W(CW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(ab_s_valid), .s_ready(b_s_ready), .s_data(ab_s_data),
        .s_last(ab_s_last), .m_valid(b_m_valid), .m_ready(ab_m_ready), .m_data(b_m_data),
        .m_sat(b_m_sat), .m_count(b_m_count));

    adder_tree_accum #(.NUM_IN(NIC), .IN_W(IW), .OUT_W(OWA), .SIGNED(1), .SAT_EN(1), .CNT_W(CW)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
        .s_last(c_s_last), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
        .m_sat(c_m_sat), .m_count(c_m_count));

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint data;
        bit     sat;
        int     cnt;
    } res_t;

    res_t   qa[$];
    res_t   qb[$];
    longint acc_a, acc_b;
    int     cnt_a, cnt_b;
    bit     sat_a, sat_b;
    bit     hold_a, hold_b;
    logic [41:0] prev_a;
    logic [37:0] prev_b;

    function automatic longint beat_sum(input logic [NI*IW-1:0] d);
        longint s;
        s = 0;
        for (int k = 0; k < NI; k++) s += longint'($signed(d[k*IW +: IW]));
        return s;
    endfunction

    function automatic longint mask(input longint v, input int ow);
        return v & ((longint'(1) <<< ow) - 1);
    endfunction

    // New accumulator value as a signed integer: clamp to range or wrap to ow bits.
    function automatic longint acc_step(input longint v, input int ow, input bit sat_en, output bit hit);
        longint hi, lo, m, w;
        hi  = (longint'(1) <<< (ow - 1)) - 1;
        lo  = -hi - 1;
        m   = longint'(1) <<< ow;
        hit = 1'b0;
        w   = v;
        if (sat_en) begin
            if (v > hi) begin w = hi; hit = 1'b1; end
            else if (v < lo) begin w = lo; hit = 1'b1; end
        end else begin
            w = v & (m - 1);
            if (w > hi) w = w - m;
        end
        return w;
    endfunction

    function automatic logic [NI*IW-1:0] rand_beat();
        logic [NI*IW-1:0] d;
        logic [15:0] ch;
        for (int k = 0; k < NI; k++) begin
            case ($urandom_range(0, 7))
                0: ch = 16'h7FFF;
                1: ch = 16'h8000;
                default: ch = 16'($urandom);
            endcase
            d[k*IW +: IW] = ch;
        end
        return d;
    endfunction

    always begin
        @(posedge clk);
        #1;
        rr_bit = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: outputs against queued expectations, stall stability, model update on accept.
    always @(negedge clk) begin
        res_t e;
        bit   hit;
        if (!rst_n) begin
            qa.delete(); qb.delete();
            acc_a = 0; acc_b = 0; cnt_a = 0; cnt_b = 0; sat_a = 0; sat_b = 0;
            hold_a = 0; hold_b = 0;
        end else begin
            if (hold_a) check("a_stall_stable", {a_m_valid, a_m_sat, a_m_count, a_m_data}, prev_a);
            if (hold_b) check("b_stall_stable", {b_m_valid, b_m_sat, b_m_count, b_m_data}, prev_b);
            hold_a = a_m_valid && !ab_m_ready;
            hold_b = b_m_valid && !ab_m_ready;
            prev_a = {a_m_valid, a_m_sat, a_m_count, a_m_data};
            prev_b = {b_m_valid, b_m_sat, b_m_count, b_m_data};

            if (a_m_valid && ab_m_ready) begin
                if (qa.size() > 0) e = qa.pop_front();
                else begin e.data = -1; e.sat = 1'b1; e.cnt = -1; end
                check("a_data", a_m_data, mask(e.data, OWA));
                check("a_sat", a_m_sat, e.sat);
                check("a_count", a_m_count, e.cnt);
            end
            if (b_m_valid && ab_m_ready) begin
                if (qb.size() > 0) e = qb.pop_front();
                else begin e.data = -1; e.sat = 1'b0; e.cnt = -1; end
                check("b_data", b_m_data, mask(e.data, OWB));
                check("b_sat", b_m_sat, e.sat);
                check("b_count", b_m_count, e.cnt);
            end

            if (ab_s_valid && a_s_ready) begin
                acc_a = acc_step(acc_a + beat_sum(ab_s_data), OWA, 1'b0, hit);
                sat_a = sat_a | hit;
                cnt_a = (cnt_a < 65535) ? cnt_a + 1 : cnt_a;
                if (ab_s_last) begin
                    e.data = acc_a; e.sat = sat_a; e.cnt = cnt_a;
                    qa.push_back(e);
                    acc_a = 0; sat_a = 0; cnt_a = 0;
                end
            end
            if (ab_s_valid && b_s_ready) begin
                acc_b = acc_step(acc_b + beat_sum(ab_s_data), OWB, 1'b1, hit);
                sat_b = sat_b | hit;
                cnt_b = (cnt_b < 65535) ? cnt_b + 1 : cnt_b;
                if (ab_s_last) begin
                    e.data = acc_b; e.sat = sat_b; e.cnt = cnt_b;
                    qb.push_back(e);
                    acc_b = 0; sat_b = 0; cnt_b = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_ab(input logic [NI*IW-1:0] d, input logic l);
        int n;
        ab_s_valid = 1'b1;
        ab_s_data  = d;
        ab_s_last  = l;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (a_s_ready) break;
            @(posedge clk); #1;
            n++;
        end
        check("accept_in_time", n < 200, 1'b1);
        @(posedge clk); #1;
        ab_s_valid = 1'b0;
    endtask

    // Cycles counted from the accepting edge (1) up to the edge after which m_valid is seen.
    task automatic wait_a(output int lat);
        lat = 1;
        while (lat < 60) begin
            @(negedge clk);
            if (a_m_valid) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [NI*IW-1:0] fill(input logic [15:0] v);
        logic [NI*IW-1:0] d;
        for (int k = 0; k < NI; k++) d[k*IW +: IW] = v;
        return d;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        logic [NI*IW-1:0] d;

        rst_n = 1'b0; ab_s_valid = 1'b0; ab_s_last = 1'b0; ab_s_data = '0;
        rdy_fix = 1'b1; rr_en = 1'b0; rr_bit = 1'b1;
        c_s_valid = 1'b0; c_s_last = 1'b0; c_s_data = '0; c_m_ready = 1'b1;

        idle(3);
        @(negedge clk);
        check("rst_m_valid", a_m_valid, 0);
        check("rst_m_data", a_m_data, 0);
        check("rst_m_count", a_m_count, 0);
        check("rst_m_sat", b_m_sat, 0);
        check("rst_s_ready", a_s_ready, 1);
        check("rst_c_s_ready", c_s_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", a_s_ready, 1);
        @(posedge clk); #1;

        // channels 1..8, single-beat group
        for (int k = 0; k < NI; k++) d[k*IW +: IW] = 16'(k + 1);
        send_ab(d, 1'b1);
        wait_a(lat);
        check("s1_latency", lat, 4);
        check("s1_data", a_m_data, 36);
        check("s1_count", a_m_count, 1);
        check("s1_sat", a_m_sat, 0);
        check("s1_b_data", b_m_data, 36);
        @(posedge clk); #1;

        // all channels at the negative extreme
        send_ab(fill(16'h8000), 1'b1);
        wait_a(lat);
        check("s2_data", a_m_data, mask(-262144, OWA));
        check("s2_sat", a_m_sat, 0);
        check("s2_b_data", b_m_data, mask(-262144, OWB));
        check("s2_b_sat", b_m_sat, 0);
        @(posedge clk); #1;

        // three max beats: 20-bit saturates, 24-bit does not; then a one-beat group of ones
        send_ab(fill(16'h7FFF), 1'b0);
        send_ab(fill(16'h7FFF), 1'b0);
        send_ab(fill(16'h7FFF), 1'b1);
        wait_a(lat);
        check("s3_b_data", b_m_data, 524287);
        check("s3_b_sat", b_m_sat, 1);
        check("s3_b_count", b_m_count, 3);
        check("s3_a_data", a_m_data, 786408);
        check("s3_a_sat", a_m_sat, 0);
        @(posedge clk); #1;
        send_ab(fill(16'h0001), 1'b1);
        wait_a(lat);
        check("s3_next_data", b_m_data, 8);
        check("s3_next_sat", b_m_sat, 0);
        check("s3_next_count", b_m_count, 1);
        @(posedge clk); #1;

        // long group: the non-saturating instance wraps, the saturating one clamps
        for (int i = 0; i < 40; i++) send_ab(fill(16'h7FFF), (i == 39));
        wait_a(lat);
        check("wrap_a_data", a_m_data, mask(40 * 262136, OWA));
        check("wrap_a_sat", a_m_sat, 0);
        check("wrap_a_count", a_m_count, 40);
        check("wrap_b_data", b_m_data, 524287);
        check("wrap_b_sat", b_m_sat, 1);
        @(posedge clk); #1;

        // back-to-back one-beat groups with a 5-cycle output stall mid-stream
        for (int i = 0; i < 6; i++) send_ab(rand_beat(), 1'b1);
        rdy_fix = 1'b0;
        d = rand_beat();
        ab_s_valid = 1'b1; ab_s_data = d; ab_s_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_s_ready", a_s_ready, 0);
            check("stall_m_valid", a_m_valid, 1);
            @(posedge clk); #1;
        end
        rdy_fix = 1'b1;
        send_ab(d, 1'b1);
        for (int i = 0; i < 4; i++) send_ab(rand_beat(), 1'b1);
        idle(12);
        check("stall_drain_a", qa.size(), 0);
        check("stall_drain_b", qb.size(), 0);

        // five-channel instance: depth 3
        for (int k = 0; k < NIC; k++) c_s_data[k*IW +: IW] = 16'(k + 1);
        c_s_valid = 1'b1; c_s_last = 1'b1;
        @(posedge clk); #1;
        c_s_valid = 1'b0;
        lat = 1;
        while (lat < 60) begin
            @(negedge clk);
            if (c_m_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("c_latency", lat, 4);
        check("c_data", c_m_data, 15);
        check("c_count", c_m_count, 1);
        @(posedge clk); #1;

        // reset in the middle of a group discards it
        send_ab(fill(16'd100), 1'b0);
        send_ab(fill(16'd100), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", a_m_valid, 0);
        check("midrst_m_data", a_m_data, 0);
        check("midrst_m_count", a_m_count, 0);
        check("midrst_b_data", b_m_data, 0);
        check("midrst_b_sat", b_m_sat, 0);
        check("midrst_s_ready", a_s_ready, 1);
        @(posedge clk); #1;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send_ab(fill(16'h0001), 1'b1);
        wait_a(lat);
        check("postrst_data", a_m_data, 8);
        check("postrst_count", a_m_count, 1);
        @(posedge clk); #1;

        // random traffic with random output backpressure
        rr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_ab(rand_beat(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        send_ab(rand_beat(), 1'b1);
        rr_en = 1'b0;
        idle(20);
        check("rand_drain_a", qa.size(), 0);
        check("rand_drain_b", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
